// File: rtl/header_shift_loader.sv
// -----------------------------------------------------------------------------
// header_shift_loader
//
// Byte-stream front end for the mining controller. It hunts for a two-byte
// sync pattern (SYNC_B0, SYNC_B1), then shifts in MID_BYTES of SHA-256
// midstate followed by TAIL_BYTES of block-header tail. The loaded words are
// held stable until the controller reports IDLE (ctrl_state == 3'b000).
//
// Optional feature: define HDR_TIMEOUT_EN to abort a load after
// TIMEOUT_CYCLES consecutive idle cycles in SYNC1, LOAD_MID or LOAD_TAIL.
// Without it, load_abort is constant 0 and gaps are unbounded.
//
// Ports:
//   clk                    system clock, rising edge
//   n_rst                  asynchronous active-low reset
//   rx_data[7:0]           incoming byte
//   rx_valid               rx_data valid this cycle
//   rx_ready               loader accepts a byte this cycle
//   ctrl_state[2:0]        controller state, 3'b000 = IDLE (used only in DONE)
//   start_found            one-cycle pulse after the sync pattern is taken
//   midstate_shifts_done   level: midstate fully loaded
//   remaining_shifts_done  level: header tail fully loaded
//   midstate               loaded midstate, first byte in the MSBs
//   header_tail            loaded tail, first byte in the MSBs
//   load_abort             one-cycle pulse on load timeout
// -----------------------------------------------------------------------------
module header_shift_loader #(
    parameter logic [7:0] SYNC_B0    = 8'h55,
    parameter logic [7:0] SYNC_B1    = 8'hAA,
    parameter int         MID_BYTES  = 32,
    parameter int         TAIL_BYTES = 12
`ifdef HDR_TIMEOUT_EN
    ,
    parameter int         TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    input  logic [2:0]              ctrl_state,
    output logic                    start_found,
    output logic                    midstate_shifts_done,
    output logic                    remaining_shifts_done,
    output logic [8*MID_BYTES-1:0]  midstate,
    output logic [8*TAIL_BYTES-1:0] header_tail,
    output logic                    load_abort
);

    typedef enum logic [2:0] {
        S_HUNT,
        S_SYNC1,
        S_LOAD_MID,
        S_LOAD_TAIL,
        S_DONE
    } state_t;

    localparam logic [5:0] MID_LAST  = 6'(MID_BYTES - 1);
    localparam logic [5:0] TAIL_LAST = 6'(TAIL_BYTES - 1);

    state_t     state_q, state_d;
    logic [5:0] cnt_q;
    logic       accept;
    logic       sync_hit;
    logic       mid_shift;
    logic       tail_shift;
    logic       timeout_hit;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path leaves a value unassigned and no latch is inferred.
    always_comb begin
        rx_ready              = (state_q != S_DONE);
        accept                = rx_valid && rx_ready;
        midstate_shifts_done  = (state_q == S_LOAD_TAIL) || (state_q == S_DONE);
        remaining_shifts_done = (state_q == S_DONE);
        state_d               = state_q;
        sync_hit              = 1'b0;
        mid_shift             = 1'b0;
        tail_shift            = 1'b0;

        case (state_q)
            S_HUNT: begin
                if (accept && rx_data == SYNC_B0) state_d = S_SYNC1;
            end
            S_SYNC1: begin
                if (accept) begin
                    if (rx_data == SYNC_B1) begin
                        state_d  = S_LOAD_MID;
                        sync_hit = 1'b1;
                    end else if (rx_data != SYNC_B0) begin
                        // A repeated SYNC_B0 may still be the start of a sync.
                        state_d = S_HUNT;
                    end
                end
            end
            S_LOAD_MID: begin
                if (accept) begin
                    mid_shift = 1'b1;
                    if (cnt_q == MID_LAST) state_d = S_LOAD_TAIL;
                end
            end
            S_LOAD_TAIL: begin
                if (accept) begin
                    tail_shift = 1'b1;
                    if (cnt_q == TAIL_LAST) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ctrl_state == 3'b000) state_d = S_HUNT;
            end
            default: state_d = S_HUNT;
        endcase

        // The timeout overrides whatever the load section decided.
        if (timeout_hit) state_d = S_HUNT;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_q <= S_HUNT;
        else        state_q <= state_d;
    end

    // NOTE: the wide shift registers are reset as well, because a reset in the
    // middle of a load must leave no partial data visible.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q       <= '0;
            midstate    <= '0;
            header_tail <= '0;
            start_found <= 1'b0;
        end else begin
            start_found <= sync_hit;
            if (timeout_hit) begin
                cnt_q       <= '0;
                midstate    <= '0;
                header_tail <= '0;
            end else if (mid_shift) begin
                midstate <= {midstate[8*MID_BYTES-9:0], rx_data};
                cnt_q    <= (cnt_q == MID_LAST) ? 6'd0 : cnt_q + 6'd1;
            end else if (tail_shift) begin
                header_tail <= {header_tail[8*TAIL_BYTES-9:0], rx_data};
                cnt_q       <= (cnt_q == TAIL_LAST) ? 6'd0 : cnt_q + 6'd1;
            end
        end
    end

`ifdef HDR_TIMEOUT_EN
    localparam logic [9:0] IDLE_LAST = 10'(TIMEOUT_CYCLES - 1);

    logic [9:0] idle_q;
    logic       in_load;

    assign in_load     = (state_q == S_SYNC1) || (state_q == S_LOAD_MID) ||
                         (state_q == S_LOAD_TAIL);
    // Fires on the TIMEOUT_CYCLES-th consecutive cycle without an accepted byte.
    assign timeout_hit = in_load && !accept && (idle_q == IDLE_LAST);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            idle_q     <= '0;
            load_abort <= 1'b0;
        end else begin
            load_abort <= timeout_hit;
            if (!in_load || accept || timeout_hit) idle_q <= '0;
            else                                   idle_q <= idle_q + 10'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign load_abort  = 1'b0;
`endif

endmodule

// File: tb/tb_header_shift_loader.sv
// -----------------------------------------------------------------------------
// tb_header_shift_loader
//
// Self-checking bench for header_shift_loader. A behavioural model tracks the
// byte stream as "hunting / saw first sync byte / N bytes loaded" and derives
// every expected output from that. Define HDR_TIMEOUT_EN for both files to
// exercise the load timeout.
// -----------------------------------------------------------------------------
module tb_header_shift_loader;

    localparam int MID   = 32;
    localparam int TAIL  = 12;
    localparam int TOTAL = MID + TAIL;
    localparam logic [7:0] B0 = 8'h55;
    localparam logic [7:0] B1 = 8'hAA;

    logic               clk = 1'b0;
    logic               n_rst;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready;
    logic [2:0]         ctrl_state;
    logic               start_found;
    logic               midstate_shifts_done;
    logic               remaining_shifts_done;
    logic [8*MID-1:0]   midstate;
    logic [8*TAIL-1:0]  header_tail;
    logic               load_abort;

    header_shift_loader dut (
        .clk                   (clk),
        .n_rst                 (n_rst),
        .rx_data               (rx_data),
        .rx_valid              (rx_valid),
        .rx_ready              (rx_ready),
        .ctrl_state            (ctrl_state),
        .start_found           (start_found),
        .midstate_shifts_done  (midstate_shifts_done),
        .remaining_shifts_done (remaining_shifts_done),
        .midstate              (midstate),
        .header_tail           (header_tail),
        .load_abort            (load_abort)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int sf_seen = 0;
    int abort_seen = 0;

    // Behavioural model: stream position, not RTL states.
    bit               m_synced;   // sync pattern seen, load in progress or complete
    bit               m_saw_b0;   // hunting, and last accepted byte was SYNC_B0
    int               m_got;      // payload bytes loaded since sync
    int               m_idle;     // idle cycles while a load is pending
    bit               m_sf;
    bit               m_abort;
    logic [8*MID-1:0]  m_mid;
    logic [8*TAIL-1:0] m_tail;
    logic [8*MID-1:0]  ref_mid;
    logic [8*TAIL-1:0] ref_tail;

    task automatic model_reset();
        m_synced = 0; m_saw_b0 = 0; m_got = 0; m_idle = 0;
        m_sf = 0; m_abort = 0; m_mid = '0; m_tail = '0;
    endtask

    task automatic model_edge(input logic v, input logic [7:0] d, input logic [2:0] cs);
        bit full;
        bit acc;
        full    = m_synced && (m_got == TOTAL);
        acc     = v && !full;
        m_sf    = 0;
        m_abort = 0;
        if (full) begin
            if (cs == 3'b000) begin
                m_synced = 0; m_saw_b0 = 0; m_got = 0;
            end
        end else if (acc) begin
            if (!m_synced) begin
                if (m_saw_b0 && d == B1) begin
                    m_synced = 1; m_saw_b0 = 0; m_got = 0; m_sf = 1;
                end else begin
                    m_saw_b0 = (d == B0);
                end
            end else begin
                if (m_got < MID) m_mid  = {m_mid[8*MID-9:0], d};
                else             m_tail = {m_tail[8*TAIL-9:0], d};
                m_got++;
            end
        end
`ifdef HDR_TIMEOUT_EN
        if (!acc && (m_saw_b0 || (m_synced && m_got < TOTAL))) begin
            m_idle++;
            if (m_idle == 1024) begin
                m_idle = 0; m_synced = 0; m_saw_b0 = 0; m_got = 0;
                m_mid = '0; m_tail = '0; m_abort = 1;
            end
        end else begin
            m_idle = 0;
        end
`endif
    endtask

    // One clock of stimulus; afterwards every output is compared against the model.
    task automatic drive_cycle(input logic v, input logic [7:0] d, input logic [2:0] cs);
        logic exp_ready, exp_md, exp_rd;
        @(negedge clk);
        rx_valid = v; rx_data = d; ctrl_state = cs;
        @(posedge clk);
        model_edge(v, d, cs);
        #1;
        exp_ready = !(m_synced && m_got == TOTAL);
        exp_md    = m_synced && (m_got >= MID);
        exp_rd    = m_synced && (m_got == TOTAL);
        n_vec++;
        if (start_found) sf_seen++;
        if (load_abort)  abort_seen++;
        if (rx_ready !== exp_ready) begin
            n_miss++; $display("FAIL rx_ready t=%0t got=%b exp=%b", $time, rx_ready, exp_ready);
        end
        if (start_found !== m_sf) begin
            n_miss++; $display("FAIL start_found t=%0t got=%b exp=%b", $time, start_found, m_sf);
        end
        if (midstate_shifts_done !== exp_md) begin
            n_miss++; $display("FAIL mid_done t=%0t got=%b exp=%b", $time, midstate_shifts_done, exp_md);
        end
        if (remaining_shifts_done !== exp_rd) begin
            n_miss++; $display("FAIL rem_done t=%0t got=%b exp=%b", $time, remaining_shifts_done, exp_rd);
        end
        if (load_abort !== m_abort) begin
            n_miss++; $display("FAIL load_abort t=%0t got=%b exp=%b", $time, load_abort, m_abort);
        end
        if (midstate !== m_mid) begin
            n_miss++; $display("FAIL midstate t=%0t got=%h exp=%h", $time, midstate, m_mid);
        end
        if (header_tail !== m_tail) begin
            n_miss++; $display("FAIL header_tail t=%0t got=%h exp=%h", $time, header_tail, m_tail);
        end
    endtask

    task automatic send_sync();
        drive_cycle(1'b1, B0, 3'b011);
        drive_cycle(1'b1, B1, 3'b011);
    endtask

    task automatic send_bytes(input int n, input int gap, input bit counting, input int base);
        for (int i = 0; i < n; i++) begin
            drive_cycle(1'b1, counting ? 8'(base + i) : 8'($urandom), 3'b011);
            for (int g = 0; g < gap; g++) drive_cycle(1'b0, 8'($urandom), 3'b011);
        end
    endtask

    task automatic release_done();
        drive_cycle(1'b0, 8'h00, 3'b000);
    endtask

    task automatic check_cleared(input string tag);
        n_vec++;
        if (rx_ready !== 1'b1 || start_found !== 1'b0 || midstate_shifts_done !== 1'b0 ||
            remaining_shifts_done !== 1'b0 || load_abort !== 1'b0 ||
            midstate !== '0 || header_tail !== '0) begin
            n_miss++;
            $display("FAIL %s rdy=%b sf=%b md=%b rd=%b ab=%b mid=%h tail=%h exp rdy=1 rest=0",
                     tag, rx_ready, start_found, midstate_shifts_done,
                     remaining_shifts_done, load_abort, midstate, header_tail);
        end
    endtask

    task automatic test_reset();
        n_rst = 1'b0; rx_valid = 1'b0; rx_data = '0; ctrl_state = 3'b011;
        model_reset();
        #12;
        check_cleared("reset_values");
        @(negedge clk);
        n_rst = 1'b1;
        drive_cycle(1'b0, 8'h00, 3'b011);
    endtask

    task automatic test_basic();
        int sf0;
        sf0 = sf_seen;
        send_sync();
        n_vec++;
        if (start_found !== 1'b1) begin
            n_miss++; $display("FAIL basic_sf_after_aa got=%b exp=1", start_found);
        end
        send_bytes(MID - 1, 0, 1, 0);
        n_vec++;
        if (midstate_shifts_done !== 1'b0) begin
            n_miss++; $display("FAIL basic_md_early got=%b exp=0", midstate_shifts_done);
        end
        drive_cycle(1'b1, 8'h1F, 3'b011);
        n_vec++;
        if (midstate_shifts_done !== 1'b1 || midstate !== ref_mid) begin
            n_miss++; $display("FAIL basic_mid md=%b got=%h exp=%h", midstate_shifts_done, midstate, ref_mid);
        end
        send_bytes(TAIL, 0, 1, MID);
        n_vec++;
        if (remaining_shifts_done !== 1'b1 || header_tail !== ref_tail || sf_seen != sf0 + 1) begin
            n_miss++;
            $display("FAIL basic_tail rd=%b got=%h exp=%h sf_pulses=%0d exp=1",
                     remaining_shifts_done, header_tail, ref_tail, sf_seen - sf0);
        end
    endtask

    task automatic test_done_hold();
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 8'($urandom), 3'b011);
        n_vec++;
        if (rx_ready !== 1'b0 || midstate !== ref_mid || header_tail !== ref_tail) begin
            n_miss++; $display("FAIL done_hold rdy=%b mid=%h tail=%h exp rdy=0 frozen", rx_ready, midstate, header_tail);
        end
        release_done();
        n_vec++;
        if (rx_ready !== 1'b1 || midstate_shifts_done !== 1'b0 || remaining_shifts_done !== 1'b0 ||
            midstate !== ref_mid) begin
            n_miss++;
            $display("FAIL done_exit rdy=%b md=%b rd=%b mid=%h exp rdy=1 md=0 rd=0 mid kept",
                     rx_ready, midstate_shifts_done, remaining_shifts_done, midstate);
        end
    endtask

    task automatic test_false_sync();
        int sf0;
        sf0 = sf_seen;
        drive_cycle(1'b1, 8'h55, 3'b011);
        drive_cycle(1'b1, 8'h12, 3'b011);
        drive_cycle(1'b1, 8'hAA, 3'b011);
        drive_cycle(1'b0, 8'h00, 3'b011);
        n_vec++;
        if (sf_seen != sf0) begin
            n_miss++; $display("FAIL false_sync_55_12_aa pulses=%0d exp=0", sf_seen - sf0);
        end
        drive_cycle(1'b1, 8'h55, 3'b011);
        drive_cycle(1'b1, 8'h55, 3'b011);
        drive_cycle(1'b1, 8'hAA, 3'b011);
        n_vec++;
        if (start_found !== 1'b1 || sf_seen != sf0 + 1) begin
            n_miss++; $display("FAIL sync_55_55_aa sf=%b pulses=%0d exp 1", start_found, sf_seen - sf0);
        end
        send_bytes(TOTAL, 0, 0, 0);
        release_done();
    endtask

    task automatic test_reset_midload();
        send_sync();
        send_bytes(10, 0, 0, 0);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        model_reset();
        check_cleared("reset_midload");
        @(negedge clk);
        n_rst = 1'b1;
        send_sync();
        send_bytes(MID, 0, 1, 0);
        send_bytes(TAIL, 0, 1, MID);
        n_vec++;
        if (midstate !== ref_mid || header_tail !== ref_tail || remaining_shifts_done !== 1'b1) begin
            n_miss++; $display("FAIL reload_after_reset mid=%h tail=%h rd=%b", midstate, header_tail, remaining_shifts_done);
        end
        release_done();
    endtask

    task automatic test_gaps();
        send_sync();
        send_bytes(MID, 3, 1, 0);
        send_bytes(TAIL, 3, 1, MID);
        n_vec++;
        if (midstate !== ref_mid || header_tail !== ref_tail) begin
            n_miss++; $display("FAIL gaps mid=%h tail=%h exp mid=%h tail=%h", midstate, header_tail, ref_mid, ref_tail);
        end
        release_done();
    endtask

`ifdef HDR_TIMEOUT_EN
    task automatic test_timeout();
        int ab0;
        ab0 = abort_seen;
        send_sync();
        send_bytes(5, 0, 0, 0);
        for (int i = 0; i < 1024; i++) drive_cycle(1'b0, 8'h00, 3'b011);
        n_vec++;
        if (abort_seen != ab0 + 1 || midstate !== '0) begin
            n_miss++; $display("FAIL timeout pulses=%0d exp=1 mid=%h exp=0", abort_seen - ab0, midstate);
        end
        drive_cycle(1'b0, 8'h00, 3'b011);
        send_sync();
        send_bytes(MID, 0, 1, 0);
        send_bytes(TAIL, 0, 1, MID);
        n_vec++;
        if (midstate !== ref_mid || header_tail !== ref_tail || abort_seen != ab0 + 1) begin
            n_miss++; $display("FAIL resync_after_timeout mid=%h tail=%h", midstate, header_tail);
        end
        release_done();
    endtask
`else
    task automatic test_long_gap();
        send_sync();
        send_bytes(5, 0, 0, 0);
        for (int i = 0; i < 1100; i++) drive_cycle(1'b0, 8'h00, 3'b011);
        send_bytes(TOTAL - 5, 0, 0, 0);
        n_vec++;
        if (abort_seen != 0 || remaining_shifts_done !== 1'b1) begin
            n_miss++; $display("FAIL long_gap aborts=%0d exp=0 rd=%b exp=1", abort_seen, remaining_shifts_done);
        end
        release_done();
    endtask
`endif

    task automatic test_random();
        logic [7:0] d;
        logic [2:0] cs;
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1:    d = B0;
                2:       d = B1;
                default: d = 8'($urandom);
            endcase
            cs = ($urandom_range(0, 5) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
            drive_cycle($urandom_range(0, 3) != 0, d, cs);
        end
    endtask

    initial begin
        for (int i = 0; i < MID; i++)  ref_mid[8*MID-1-8*i -: 8]   = 8'(i);
        for (int i = 0; i < TAIL; i++) ref_tail[8*TAIL-1-8*i -: 8] = 8'(MID + i);
        test_reset();
        test_basic();
        test_done_hold();
        test_false_sync();
        test_reset_midload();
        test_gaps();
`ifdef HDR_TIMEOUT_EN
        test_timeout();
`else
        test_long_gap();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
